// File: rtl/adder_tree_packer.sv
// rtl/adder_tree_packer.sv - ping-pong lane packer feeding the BFP32 reduction adder tree
module adder_tree_packer #(
    parameter int BETA          = 16,
    parameter int ADD_DATAWIDTH = 32,
    parameter int CNT_W         = $clog2(BETA + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADD_DATAWIDTH-1:0]              in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [BETA-1:0][ADD_DATAWIDTH-1:0]    out_data,
    output logic [CNT_W-1:0]                      out_count,
    output logic                                  out_last
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BETA - 1);

    // Two banks: one fills from the input while the other waits for the tree.
    logic [BETA-1:0][ADD_DATAWIDTH-1:0] bank_q [2];
    logic [CNT_W-1:0]                   cnt_q  [2];
    logic                               last_q [2];
    logic                               full_q [2];
    logic                               wp_q;
    logic                               rp_q;
    logic [CNT_W-1:0]                   lane_q;

    logic in_hs;
    logic out_hs;
    logic close_grp;

    // Readiness comes only from registered flags, so out_ready never reaches in_ready.
    assign in_ready  = !full_q[wp_q];
    assign out_valid = full_q[rp_q];
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign close_grp = in_hs && ((lane_q == LAST_LANE) || in_last);

    // Control state: lane tracking, group close into wp bank, drain of rp bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                cnt_q[b]  <= '0;
                last_q[b] <= 1'b0;
                full_q[b] <= 1'b0;
            end
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            lane_q <= '0;
        end else begin
            if (in_hs) begin
                if (close_grp) begin
                    cnt_q[wp_q]  <= lane_q + CNT_W'(1);
                    last_q[wp_q] <= in_last;
                    full_q[wp_q] <= 1'b1;
                    wp_q         <= ~wp_q;
                    lane_q       <= '0;
                end else begin
                    lane_q <= lane_q + CNT_W'(1);
                end
            end
            // A close always targets the non-full bank, a drain the full one,
            // so these never touch the same flag in one cycle.
            if (out_hs) begin
                full_q[rp_q] <= 1'b0;
                rp_q         <= ~rp_q;
            end
        end
    end

    // Bank storage: stale lanes are masked on the output, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            for (int i = 0; i < BETA; i++) begin
                if (lane_q == CNT_W'(i)) begin
                    bank_q[wp_q][i] <= in_data;
                end
            end
        end
    end

    // Output view of the read bank; pad lanes are forced to zero because the tree sums every lane.
    always_comb begin
        out_data  = '0;
        out_count = '0;
        out_last  = 1'b0;
        if (full_q[rp_q]) begin
            out_count = cnt_q[rp_q];
            out_last  = last_q[rp_q];
            for (int i = 0; i < BETA; i++) begin
                if (CNT_W'(i) < cnt_q[rp_q]) begin
                    out_data[i] = bank_q[rp_q][i];
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_packer.sv
// tb/tb_adder_tree_packer.sv - randomized and directed checks of adder_tree_packer against a queue model
module tb_adder_tree_packer;

    localparam int BETA  = 4;
    localparam int W     = 32;
    localparam int CNT_W = $clog2(BETA + 1);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [W-1:0]               in_data = '0;
    logic                       in_last = 1'b0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [BETA-1:0][W-1:0]     out_data;
    logic [CNT_W-1:0]           out_count;
    logic                       out_last;

    adder_tree_packer #(.BETA(BETA), .ADD_DATAWIDTH(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int accepted = 0;
    int stalls = 0;

    typedef struct {
        logic [BETA-1:0][W-1:0] d;
        int                     cnt;
        bit                     last;
    } vec_t;

    vec_t   expq[$];
    logic [W-1:0] grp[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending vectors are a FIFO of at most two; the open group is a word queue.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            grp.delete();
            chk("rst_in_ready", 512'(in_ready), 512'(1));
            chk("rst_out_valid", 512'(out_valid), 512'(0));
            chk("rst_out_data", 512'(out_data), 512'(0));
            chk("rst_out_count", 512'(out_count), 512'(0));
            chk("rst_out_last", 512'(out_last), 512'(0));
        end else begin
            bit exp_ready;
            exp_ready = (expq.size() < 2);
            chk("in_ready", 512'(in_ready), 512'(exp_ready));
            if (expq.size() > 0) begin
                chk("out_valid", 512'(out_valid), 512'(1));
                chk("out_data", 512'(out_data), 512'(expq[0].d));
                chk("out_count", 512'(out_count), 512'(expq[0].cnt));
                chk("out_last", 512'(out_last), 512'(expq[0].last));
            end else begin
                chk("idle_out_valid", 512'(out_valid), 512'(0));
                chk("idle_out_data", 512'(out_data), 512'(0));
                chk("idle_out_count", 512'(out_count), 512'(0));
                chk("idle_out_last", 512'(out_last), 512'(0));
            end
            if (expq.size() > 0 && out_ready) void'(expq.pop_front());
            if (in_valid && exp_ready) begin
                grp.push_back(in_data);
                if (grp.size() == BETA || in_last) begin
                    vec_t v;
                    v.d    = '0;
                    v.cnt  = grp.size();
                    v.last = in_last;
                    for (int i = 0; i < grp.size(); i++) v.d[i] = grp[i];
                    expq.push_back(v);
                    grp.delete();
                end
            end
        end
    end

    // Present one word and hold it until accepted; called and returns at posedge+1.
    task automatic put(input logic [W-1:0] d, input bit l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL put_timeout: got stalled %0d cycles expected accept", t);
        end
        stalls += t;
        @(posedge clk);
        #1;
        accepted++;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [BETA-1:0][W-1:0] e;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);

        // Full group of 4 floats
        out_ready = 1'b1;
        put(32'h3F800000, 0);
        put(32'h40000000, 0);
        put(32'h40400000, 0);
        put(32'h40800000, 0);
        e = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        chk("t1_valid", 512'(out_valid), 512'(1));
        chk("t1_data", 512'(out_data), 512'(e));
        chk("t1_count", 512'(out_count), 512'(4));
        chk("t1_last", 512'(out_last), 512'(0));
        tick(2);

        // Filler group into the other bank, then a short group back into bank 0 over stale lanes
        put(32'h41100000, 0);
        put(32'h41200000, 0);
        put(32'h41300000, 0);
        put(32'h41400000, 0);
        tick(2);
        put(32'h40A00000, 0);
        put(32'h40C00000, 1);
        e = {32'h0, 32'h0, 32'h40C00000, 32'h40A00000};
        chk("t2_data", 512'(out_data), 512'(e));
        chk("t2_count", 512'(out_count), 512'(2));
        chk("t2_last", 512'(out_last), 512'(1));
        tick(2);

        // Backpressure: 12 words with the output blocked
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int k = 1; k <= 12; k++) put(W'(k), 0);
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                chk("bp_accepted", 512'(accepted), 512'(8));
                chk("bp_in_ready", 512'(in_ready), 512'(0));
                chk("bp_lane0", 512'(out_data[0]), 512'(1));
                out_ready = 1'b1;
            end
        join
        tick(4);

        // Single-word groups back to back: never stalls
        stalls = 0;
        for (int k = 0; k < 8; k++) put(W'(32'h100 + k), 1);
        chk("single_stalls", 512'(stalls), 512'(0));
        tick(2);

        // Close on bank1 in the same cycle bank0 drains
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) put(W'(32'h200 + k), 0);
        for (int k = 0; k < 3; k++) put(W'(32'h300 + k), 0);
        out_ready = 1'b1;
        put(32'h303, 0);
        e = {32'h303, 32'h302, 32'h301, 32'h300};
        chk("cd_valid", 512'(out_valid), 512'(1));
        chk("cd_data", 512'(out_data), 512'(e));
        tick(2);

        // Reset with one vector pending and a partial group
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) put(W'(32'h400 + k), 0);
        put(32'h500, 0);
        put(32'h501, 0);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 512'(out_valid), 512'(0));
        chk("mrst_in_ready", 512'(in_ready), 512'(1));
        tick(1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) put(W'(32'h600 + k), 0);
        e = {32'h603, 32'h602, 32'h601, 32'h600};
        chk("mrst_data", 512'(out_data), 512'(e));
        chk("mrst_count", 512'(out_count), 512'(4));
        tick(2);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick(6);
        chk("drain_empty", 512'(out_valid), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
